// File: rtl/fxp_add_pkg.sv
// Shared definitions for the fixed-point add scheduler: default sizes,
// requester-index width helper and the default-width saturation limits.
package fxp_add_pkg;

   localparam int W_DEFAULT    = 64;
   localparam int NREQ_DEFAULT = 4;

   localparam logic [W_DEFAULT-1:0] SAT_MAX = {1'b0, {(W_DEFAULT-1){1'b1}}};
   localparam logic [W_DEFAULT-1:0] SAT_MIN = {1'b1, {(W_DEFAULT-1){1'b0}}};

   // Width of a requester index; a single requester still gets one bit.
   function automatic int idw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Saturation limit for the default width, selected by the sign of the operands.
   function automatic logic [W_DEFAULT-1:0] satLimit(input logic negative);
      return negative ? SAT_MIN : SAT_MAX;
   endfunction

endpackage

// File: rtl/fxp_add_core.sv
// Combinational signed adder with overflow detect. Saturation on overflow is
// built only when FXP_ADD_SAT_EN is defined; otherwise the sum wraps.
module fxp_add_core
   import fxp_add_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         ovf_o
);

   logic [W-1:0] wrapSum;
   logic         ovf;

   assign wrapSum = a_i + b_i;

   // Overflow only when operands share a sign and the result sign differs.
   assign ovf   = (a_i[W-1] == b_i[W-1]) && (wrapSum[W-1] != a_i[W-1]);
   assign ovf_o = ovf;

`ifdef FXP_ADD_SAT_EN
   localparam logic [W-1:0] SAT_MAX_W = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN_W = {1'b1, {(W-1){1'b0}}};

   always_comb begin
      sum_o = wrapSum;
      if (ovf) begin
         sum_o = a_i[W-1] ? SAT_MIN_W : SAT_MAX_W;
      end
   end
`else
   assign sum_o = wrapSum;
`endif

endmodule

// File: rtl/fxp_add_sched.sv
// Round-robin scheduler feeding one shared adder with a one-deep result register.
// Saturating results are enabled by defining FXP_ADD_SAT_EN.
module fxp_add_sched
   import fxp_add_pkg::*;
#(
   parameter int W    = W_DEFAULT,
   parameter int NREQ = NREQ_DEFAULT,
   localparam int IDW = idw(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic [IDW-1:0]    res_id,
   output logic              res_ovf
);

   logic [IDW-1:0] rrPtr_q,    rrPtr_d;
   logic           resValid_q, resValid_d;
   logic [W-1:0]   resSum_q,   resSum_d;
   logic [IDW-1:0] resId_q,    resId_d;
   logic           resOvf_q,   resOvf_d;

   logic           slotFree;
   logic           grantValid;
   logic [IDW-1:0] grantIdx;
   logic           accept;
   logic [W-1:0]   aArr [NREQ];
   logic [W-1:0]   bArr [NREQ];
   logic [W-1:0]   opA, opB;
   logic [W-1:0]   coreSum;
   logic           coreOvf;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         aArr[i] = req_a[i*W +: W];
         bArr[i] = req_b[i*W +: W];
      end
   end

   assign slotFree = !resValid_q || res_ready;

   // Search starts at the pointer and wraps; the first valid requester wins.
   always_comb begin
      int idx;
      idx        = 0;
      grantValid = 1'b0;
      grantIdx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rrPtr_q) + k) % NREQ;
         if (!grantValid && req_valid[idx]) begin
            grantValid = 1'b1;
            grantIdx   = IDW'(idx);
         end
      end
   end

   assign accept = grantValid && slotFree && !rst;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grantIdx] = 1'b1;
      end
   end

   assign opA = aArr[grantIdx];
   assign opB = bArr[grantIdx];

   fxp_add_core #(
      .W(W)
   ) u_core (
      .a_i  (opA),
      .b_i  (opB),
      .sum_o(coreSum),
      .ovf_o(coreOvf)
   );

   // An accept always loads the register, even while it drains in the same cycle.
   always_comb begin
      rrPtr_d    = rrPtr_q;
      resValid_d = resValid_q;
      resSum_d   = resSum_q;
      resId_d    = resId_q;
      resOvf_d   = resOvf_q;
      if (accept) begin
         resValid_d = 1'b1;
         resSum_d   = coreSum;
         resId_d    = grantIdx;
         resOvf_d   = coreOvf;
         rrPtr_d    = (grantIdx == IDW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
      end else if (res_ready) begin
         resValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrPtr_q    <= '0;
         resValid_q <= 1'b0;
         resSum_q   <= '0;
         resId_q    <= '0;
         resOvf_q   <= 1'b0;
      end else begin
         rrPtr_q    <= rrPtr_d;
         resValid_q <= resValid_d;
         resSum_q   <= resSum_d;
         resId_q    <= resId_d;
         resOvf_q   <= resOvf_d;
      end
   end

   assign res_valid = resValid_q;
   assign res_sum   = resSum_q;
   assign res_id    = resId_q;
   assign res_ovf   = resOvf_q;

endmodule

// File: tb/tb_fxp_add_sched.sv
// Self-checking bench for fxp_add_sched: directed scenarios plus random traffic
// compared against an arithmetic reference model (honours FXP_ADD_SAT_EN).
module tb_fxp_add_sched;

   localparam int W    = 64;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_sum;
   logic [IDW-1:0]    res_id;
   logic              res_ovf;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic            mValid;
   logic [W-1:0]    mSum;
   int              mId;
   logic            mOvf;
   int              mPtr;
   logic [NREQ-1:0] lastReady;

   fxp_add_sched #(.W(W), .NREQ(NREQ)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_sum  (res_sum),
      .res_id   (res_id),
      .res_ovf  (res_ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setOp(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   // Exact signed sum in W+1 bits; overflow means it does not fit in W bits.
   task automatic modelAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] sum, output logic ovf);
      logic signed [W:0] full;
      full = $signed({a[W-1], a}) + $signed({b[W-1], b});
      ovf  = (full > $signed({1'b0, MAXP})) || (full < $signed({1'b1, MINN}));
      sum  = full[W-1:0];
`ifdef FXP_ADD_SAT_EN
      if (ovf) sum = (full < 0) ? MINN : MAXP;
`endif
   endtask

   // Valid requester closest to the pointer, counting forward with wrap.
   function automatic logic [NREQ-1:0] modelGrant();
      int best = -1;
      int bestDist = NREQ;
      if (rst || (mValid && !res_ready)) return '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && ((i - mPtr + NREQ) % NREQ) < bestDist) begin
            bestDist = (i - mPtr + NREQ) % NREQ;
            best     = i;
         end
      end
      return (best < 0) ? '0 : NREQ'(1 << best);
   endfunction

   task automatic modelReset();
      mValid = 1'b0;
      mSum   = '0;
      mId    = 0;
      mOvf   = 1'b0;
      mPtr   = 0;
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task automatic applyStimulus(input string tag);
      logic [NREQ-1:0] expReady;
      logic [W-1:0]    s;
      logic            o;
      int              g;
      @(negedge clk);
      expReady = modelGrant();
      checkOutput({tag, " ready"}, 64'(req_ready), 64'(expReady));
      checkOutput({tag, " valid"}, 64'(res_valid), 64'(mValid));
      if (mValid) begin
         checkOutput({tag, " sum"}, res_sum, mSum);
         checkOutput({tag, " id"}, 64'(res_id), 64'(mId));
         checkOutput({tag, " ovf"}, 64'(res_ovf), 64'(mOvf));
      end
      lastReady = req_ready;
      @(posedge clk);
      if (rst) begin
         modelReset();
      end else if (expReady != '0) begin
         g = 0;
         for (int i = 0; i < NREQ; i++) if (expReady[i]) g = i;
         modelAdd(req_a[g*W +: W], req_b[g*W +: W], s, o);
         mValid = 1'b1;
         mSum   = s;
         mOvf   = o;
         mId    = g;
         mPtr   = (g + 1) % NREQ;
      end else if (res_ready) begin
         mValid = 1'b0;
      end
      #1;
   endtask

   function automatic logic [W-1:0] randOperand();
      case ($urandom_range(0, 5))
         0: return MAXP;
         1: return MINN;
         2: return '1;
         3: return 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b0;
      modelReset();
      lastReady = '0;

      // Reset state
      #2;
      checkOutput("reset valid", 64'(res_valid), 64'd0);
      checkOutput("reset sum", res_sum, 64'd0);
      checkOutput("reset id", 64'(res_id), 64'd0);
      checkOutput("reset ovf", 64'(res_ovf), 64'd0);
      req_valid = '1;
      #1;
      checkOutput("reset ready", 64'(req_ready), 64'd0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fairness: all requesting, consumer always ready
      for (int i = 0; i < NREQ; i++) setOp(i, 64'(i * 10), 64'(i));
      req_valid = '1;
      res_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         applyStimulus("fair");
         checkOutput("fair grant", 64'(lastReady), 64'(1 << (k % NREQ)));
         checkOutput("fair id", 64'(res_id), 64'(k % NREQ));
      end
      req_valid = '0;
      applyStimulus("fair drain");

      // Single request from requester 2
      setOp(2, 64'd5, 64'd7);
      req_valid = 4'b0100;
      applyStimulus("single");
      checkOutput("single grant", 64'(lastReady), 64'b0100);
      checkOutput("single valid", 64'(res_valid), 64'd1);
      checkOutput("single sum", res_sum, 64'd12);
      checkOutput("single id", 64'(res_id), 64'd2);
      checkOutput("single ovf", 64'(res_ovf), 64'd0);

      // Backpressure: held result, requester 1 waits
      req_valid = 4'b0010;
      setOp(1, 64'd100, 64'd23);
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus("bp hold");
         checkOutput("bp ready", 64'(lastReady), 64'd0);
         checkOutput("bp sum", res_sum, 64'd12);
         checkOutput("bp id", 64'(res_id), 64'd2);
      end
      res_ready = 1'b1;
      applyStimulus("bp release");
      checkOutput("bp grant", 64'(lastReady), 64'b0010);
      checkOutput("bp new valid", 64'(res_valid), 64'd1);
      checkOutput("bp new sum", res_sum, 64'd123);
      checkOutput("bp new id", 64'(res_id), 64'd1);
      req_valid = '0;
      applyStimulus("bp drain");
      checkOutput("bp drained", 64'(res_valid), 64'd0);

      // Overflow and wrap corners
      req_valid = 4'b0001;
      setOp(0, MAXP, 64'd1);
      applyStimulus("ovf pos");
      checkOutput("ovf pos flag", 64'(res_ovf), 64'd1);
`ifdef FXP_ADD_SAT_EN
      checkOutput("ovf pos sum", res_sum, MAXP);
`else
      checkOutput("ovf pos sum", res_sum, MINN);
`endif
      setOp(0, MINN, MINN);
      applyStimulus("ovf neg");
      checkOutput("ovf neg flag", 64'(res_ovf), 64'd1);
`ifdef FXP_ADD_SAT_EN
      checkOutput("ovf neg sum", res_sum, MINN);
`else
      checkOutput("ovf neg sum", res_sum, 64'd0);
`endif
      setOp(0, '1, 64'd1);
      applyStimulus("wrap");
      checkOutput("wrap sum", res_sum, 64'd0);
      checkOutput("wrap ovf", 64'(res_ovf), 64'd0);
      req_valid = '0;
      applyStimulus("wrap drain");

      // Reset mid-operation with pointer at 3 and a result held
      setOp(2, 64'd40, 64'd2);
      req_valid = 4'b0100;
      res_ready = 1'b0;
      applyStimulus("pre reset");
      req_valid = '0;
      checkOutput("pre reset valid", 64'(res_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("async valid", 64'(res_valid), 64'd0);
      checkOutput("async sum", res_sum, 64'd0);
      checkOutput("async id", 64'(res_id), 64'd0);
      checkOutput("async ovf", 64'(res_ovf), 64'd0);
      setOp(0, 64'd1, 64'd2);
      setOp(3, 64'd3, 64'd4);
      req_valid = 4'b1001;
      res_ready = 1'b1;
      applyStimulus("in reset");
      checkOutput("in reset ready", 64'(lastReady), 64'd0);
      rst = 1'b0;
      applyStimulus("post reset 0");
      checkOutput("post reset first", 64'(lastReady), 64'b0001);
      applyStimulus("post reset 1");
      checkOutput("post reset second", 64'(lastReady), 64'b1000);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         req_valid = NREQ'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) setOp(i, randOperand(), randOperand());
         applyStimulus("rand");
      end
      req_valid = '0;
      res_ready = 1'b1;
      applyStimulus("final drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
